// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared encodings for the register-file command master.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_ADDR_W = 2;
    localparam int DEFAULT_DATA_W = 32;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_RESP    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_COPY_RD = 3'd5,
        ST_COPY_WR = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_master.sv
`default_nettype none
// ============================================================================
// Module   : regfile_master
// Brief    : Sequences read/write/clear/copy commands onto a 2R1W register file.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_master
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              busy,
    output logic [ADDR_W-1:0] readReg1,
    output logic [ADDR_W-1:0] readReg2,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'((1 << ADDR_W) - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_b;
    logic [DATA_W-1:0] r_d;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_rspValid;
    logic [DATA_W-1:0] r_rspData1;
    logic [DATA_W-1:0] r_rspData2;
    logic [ADDR_W-1:0] r_readReg1;
    logic [ADDR_W-1:0] r_readReg2;
    logic [ADDR_W-1:0] r_writeReg;
    logic [DATA_W-1:0] r_writeData;
    logic              r_regWrite;

    // RegFile-side outputs are registered one state ahead so they are valid
    // for the whole cycle the FSM sits in the corresponding state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_rspValid  <= 1'b0;
            r_rspData1  <= '0;
            r_rspData2  <= '0;
            r_readReg1  <= '0;
            r_readReg2  <= '0;
            r_writeReg  <= '0;
            r_writeData <= '0;
            r_regWrite  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_a <= cmd_addr_a;
                        r_b <= cmd_addr_b;
                        r_d <= cmd_data;
                        case (cmd_op)
                            OP_READ: begin
                                r_state    <= ST_READ;
                                r_readReg1 <= cmd_addr_a;
                                r_readReg2 <= cmd_addr_b;
                            end
                            OP_WRITE: begin
                                r_state     <= ST_WRITE;
                                r_regWrite  <= 1'b1;
                                r_writeReg  <= cmd_addr_a;
                                r_writeData <= cmd_data;
                            end
                            OP_CLEAR: begin
                                r_state     <= ST_CLEAR;
                                r_cnt       <= '0;
                                r_regWrite  <= 1'b1;
                                r_writeReg  <= '0;
                                r_writeData <= '0;
                            end
                            default: begin
                                r_state    <= ST_COPY_RD;
                                r_readReg1 <= cmd_addr_a;
                            end
                        endcase
                    end
                end
                ST_READ: begin
                    r_rspData1 <= ReadData1;
                    r_rspData2 <= ReadData2;
                    r_rspValid <= 1'b1;
                    r_readReg1 <= '0;
                    r_readReg2 <= '0;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    r_regWrite  <= 1'b0;
                    r_writeReg  <= '0;
                    r_writeData <= '0;
                    r_state     <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt      <= '0;
                        r_regWrite <= 1'b0;
                        r_writeReg <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt      <= r_cnt + ADDR_W'(1);
                        r_writeReg <= r_cnt + ADDR_W'(1);
                    end
                end
                ST_COPY_RD: begin
                    r_d         <= ReadData1;
                    r_readReg1  <= '0;
                    r_regWrite  <= 1'b1;
                    r_writeReg  <= r_b;
                    r_writeData <= ReadData1;
                    r_state     <= ST_COPY_WR;
                end
                ST_COPY_WR: begin
                    r_regWrite  <= 1'b0;
                    r_writeReg  <= '0;
                    r_writeData <= '0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_regWrite <= 1'b0;
                    r_readReg1 <= '0;
                    r_readReg2 <= '0;
                    r_writeReg <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_data1 = r_rspData1;
    assign rsp_data2 = r_rspData2;
    assign readReg1  = r_readReg1;
    assign readReg2  = r_readReg2;
    assign WriteReg  = r_writeReg;
    assign WriteData = r_writeData;
    assign RegWrite  = r_regWrite;

endmodule
`default_nettype wire

// File: tb/tb_regfile_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_master
// Brief    : Directed self-checking bench for regfile_master with a RegFile model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_addr_a;
    logic [1:0]  cmd_addr_b;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic        busy;
    logic [1:0]  readReg1;
    logic [1:0]  readReg2;
    logic [1:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int failures = 0;
    int wrCount = 0;
    logic [31:0] rf [4];
    logic [31:0] held1;
    logic [31:0] held2;
    int wrBase;

    regfile_master dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .busy(busy),
        .readReg1(readReg1), .readReg2(readReg2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadData1(ReadData1), .ReadData2(ReadData2)
    );

    always #5 clk = ~clk;

    // Register file model: combinational reads, write on the rising edge, no reset.
    assign ReadData1 = rf[readReg1];
    assign ReadData2 = rf[readReg2];
    always @(posedge clk) begin
        if (RegWrite) begin
            rf[WriteReg] <= WriteData;
            wrCount = wrCount + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a command and returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [31:0] d);
        int n;
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("issue_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [1:0] a, input logic [31:0] d);
        issue(2'b01, a, 2'd0, d);
        tick();
    endtask

    task automatic readPair(input string tag, input logic [1:0] a, input logic [1:0] b,
                            input logic [31:0] e1, input logic [31:0] e2);
        issue(2'b00, a, b, 32'd0);
        tick();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_d1"}, rsp_data1, e1);
        check({tag, "_d2"}, rsp_data2, e2);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 32'd0;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = 2'd0; cmd_addr_a = 2'd0; cmd_addr_b = 2'd0; cmd_data = 32'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_rsp_data1", rsp_data1, 32'd0);

        // write 5 -> r0, then read (r0, r1)
        issue(2'b01, 2'd0, 2'd0, 32'd5);
        check("wr_regwrite", 32'(RegWrite), 32'd1);
        check("wr_writereg", 32'(WriteReg), 32'd0);
        check("wr_writedata", WriteData, 32'd5);
        check("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        check("wr_done_regwrite", 32'(RegWrite), 32'd0);
        check("wr_done_ready", 32'(cmd_ready), 32'd1);
        check("wr_rf0", rf[0], 32'd5);

        issue(2'b00, 2'd0, 2'd1, 32'd0);
        check("rd_readreg2", 32'(readReg2), 32'd1);
        check("rd_valid_early", 32'(rsp_valid), 32'd0);
        tick();
        check("rd_valid", 32'(rsp_valid), 32'd1);
        check("rd_d1", rsp_data1, 32'd5);
        check("rd_d2", rsp_data2, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rd_valid_done", 32'(rsp_valid), 32'd0);
        check("rd_ready_done", 32'(cmd_ready), 32'd1);

        // copy r3 -> r2
        doWrite(2'd3, 32'hDEADBEEF);
        wrBase = wrCount;
        issue(2'b11, 2'd3, 2'd2, 32'd0);
        check("cp_readreg1", 32'(readReg1), 32'd3);
        check("cp_rd_regwrite", 32'(RegWrite), 32'd0);
        tick();
        check("cp_wr_regwrite", 32'(RegWrite), 32'd1);
        check("cp_wr_writereg", 32'(WriteReg), 32'd2);
        check("cp_wr_writedata", WriteData, 32'hDEADBEEF);
        tick();
        check("cp_done_ready", 32'(cmd_ready), 32'd1);
        check("cp_write_pulses", 32'(wrCount - wrBase), 32'd1);
        readPair("cp_rd", 2'd2, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF);

        // fill and clear-all
        for (int i = 0; i < 4; i++) doWrite(2'(i), 32'(i + 1));
        readPair("fill_rd", 2'd1, 2'd3, 32'd2, 32'd4);
        issue(2'b10, 2'd0, 2'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("clr_regwrite%0d", i), 32'(RegWrite), 32'd1);
            check($sformatf("clr_writereg%0d", i), 32'(WriteReg), 32'(i));
            check($sformatf("clr_writedata%0d", i), WriteData, 32'd0);
            tick();
        end
        check("clr_done_regwrite", 32'(RegWrite), 32'd0);
        check("clr_done_ready", 32'(cmd_ready), 32'd1);
        readPair("clr_rd01", 2'd0, 2'd1, 32'd0, 32'd0);
        readPair("clr_rd23", 2'd2, 2'd3, 32'd0, 32'd0);

        // response backpressure with a pending write
        doWrite(2'd1, 32'h11);
        doWrite(2'd2, 32'h22);
        issue(2'b00, 2'd1, 2'd2, 32'd0);
        tick();
        cmd_op = 2'b01; cmd_addr_a = 2'd1; cmd_addr_b = 2'd0; cmd_data = 32'h77;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp_d1_%0d", i), rsp_data1, 32'h11);
            check($sformatf("bp_d2_%0d", i), rsp_data2, 32'h22);
            check($sformatf("bp_ready%0d", i), 32'(cmd_ready), 32'd0);
            check($sformatf("bp_nowrite%0d", i), 32'(RegWrite), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_hs_valid", 32'(rsp_valid), 32'd0);
        check("bp_hs_ready", 32'(cmd_ready), 32'd1);
        check("bp_hs_nowrite", 32'(RegWrite), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check("bp_wr_regwrite", 32'(RegWrite), 32'd1);
        check("bp_wr_writedata", WriteData, 32'h77);
        tick();
        check("bp_wr_rf1", rf[1], 32'h77);

        // reset in the middle of a clear
        doWrite(2'd2, 32'hA2);
        doWrite(2'd3, 32'hA3);
        issue(2'b10, 2'd0, 2'd0, 32'd0);
        tick();
        tick();
        check("mid_writereg", 32'(WriteReg), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_regwrite_drop", 32'(RegWrite), 32'd0);
        check("mid_ready", 32'(cmd_ready), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;
        check("mid_rf0", rf[0], 32'd0);
        check("mid_rf1", rf[1], 32'd0);
        check("mid_rf2", rf[2], 32'hA2);
        check("mid_rf3", rf[3], 32'hA3);
        check("mid_rsp_data1", rsp_data1, 32'd0);
        check("mid_writereg_rst", 32'(WriteReg), 32'd0);

        // back-to-back writes with cmd_valid held
        wrBase = wrCount;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_op = 2'b01; cmd_addr_a = 2'(i); cmd_data = 32'h100 + 32'(i);
            check($sformatf("b2b_ready%0d", i), 32'(cmd_ready), 32'd1);
            tick();
            check($sformatf("b2b_regwrite%0d", i), 32'(RegWrite), 32'd1);
            check($sformatf("b2b_writereg%0d", i), 32'(WriteReg), 32'(i));
            tick();
            check($sformatf("b2b_idle_regwrite%0d", i), 32'(RegWrite), 32'd0);
        end
        cmd_valid = 1'b0;
        tick();
        check("b2b_pulses", 32'(wrCount - wrBase), 32'd3);
        check("b2b_rf0", rf[0], 32'h100);
        check("b2b_rf2", rf[2], 32'h102);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
